// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified memory between the instruction fetch stage
// and the MEM stage of the pipeline. Data accesses always win over fetches.
// Each access is held on the memory port until mem_ack, or until the wait
// counter runs out, which raises mem_err. A flush during a fetch marks the
// returning word as stale so it is dropped. At least one idle cycle follows
// every access.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   if_req, if_addr     fetch request and byte address (PC)
//   flush               redirect; the in-flight fetch result is discarded
//   dm_read, dm_write   MEM stage load / store request (store wins if both)
//   dm_addr, dm_wdata   data byte address and store data
//   dm_funct3           access size/sign, passed through as mem_size
//   mem_ack, mem_rdata  memory completion and read data
//   mem_req, mem_we     memory request and write enable (registered)
//   mem_addr, mem_wdata memory address and write data (registered)
//   mem_size            access size, 3'b010 for fetches (registered)
//   if_rdata, if_valid  fetched word and its one-cycle valid pulse
//   dm_rdata, dm_done   load data and one-cycle data completion pulse
//   mem_err             one-cycle pulse when an access times out
//   stall_if, stall_mem combinational pipeline stalls
// -----------------------------------------------------------------------------
module mem_port_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        flush,
    input  logic        dm_read,
    input  logic        dm_write,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [2:0]  dm_funct3,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_size,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    output logic [31:0] dm_rdata,
    output logic        dm_done,
    output logic        mem_err,
    output logic        stall_if,
    output logic        stall_mem
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DATA  = 2'b01,
        FETCH = 2'b10
    } state_t;

    localparam logic [2:0] FETCH_SIZE = 3'b010;
    localparam logic [3:0] WAIT_MAX   = 4'd15;
    // A miss in the cycle that sees this count brings the counter to 15.
    localparam logic [3:0] WAIT_LAST  = 4'd14;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  wait_cnt_r;
    logic [3:0]  wait_cnt_nxt_s;
    logic        discard_r;
    logic        discard_nxt_s;

    logic        mem_req_r,   mem_req_nxt_s;
    logic        mem_we_r,    mem_we_nxt_s;
    logic [31:0] mem_addr_r,  mem_addr_nxt_s;
    logic [31:0] mem_wdata_r, mem_wdata_nxt_s;
    logic [2:0]  mem_size_r,  mem_size_nxt_s;
    logic [31:0] if_rdata_r,  if_rdata_nxt_s;
    logic        if_valid_r,  if_valid_nxt_s;
    logic [31:0] dm_rdata_r,  dm_rdata_nxt_s;
    logic        dm_done_r,   dm_done_nxt_s;
    logic        mem_err_r,   mem_err_nxt_s;

    logic        data_pending_s;
    logic        timeout_s;

    // A data request is outstanding until its done pulse has been seen.
    assign data_pending_s = (dm_read | dm_write) & ~dm_done_r;
    assign timeout_s      = (wait_cnt_r == WAIT_LAST);

    assign stall_mem = data_pending_s;
    assign stall_if  = (if_req & ~if_valid_r) | data_pending_s;

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_size  = mem_size_r;
    assign if_rdata  = if_rdata_r;
    assign if_valid  = if_valid_r;
    assign dm_rdata  = dm_rdata_r;
    assign dm_done   = dm_done_r;
    assign mem_err   = mem_err_r;

    // Next-state, wait counter, discard flag and next registered outputs.
    always_comb begin
        state_nxt_s     = state_r;
        wait_cnt_nxt_s  = wait_cnt_r;
        discard_nxt_s   = discard_r;
        mem_req_nxt_s   = mem_req_r;
        mem_we_nxt_s    = mem_we_r;
        mem_addr_nxt_s  = mem_addr_r;
        mem_wdata_nxt_s = mem_wdata_r;
        mem_size_nxt_s  = mem_size_r;
        if_rdata_nxt_s  = if_rdata_r;
        dm_rdata_nxt_s  = dm_rdata_r;
        if_valid_nxt_s  = 1'b0;
        dm_done_nxt_s   = 1'b0;
        mem_err_nxt_s   = 1'b0;

        case (state_r)
            IDLE: begin
                // mem_ack is deliberately not looked at here.
                if (data_pending_s) begin
                    state_nxt_s     = DATA;
                    wait_cnt_nxt_s  = 4'd0;
                    discard_nxt_s   = 1'b0;
                    mem_req_nxt_s   = 1'b1;
                    mem_we_nxt_s    = dm_write;
                    mem_addr_nxt_s  = dm_addr;
                    mem_wdata_nxt_s = dm_wdata;
                    mem_size_nxt_s  = dm_funct3;
                end else if (if_req && !if_valid_r && !flush) begin
                    state_nxt_s     = FETCH;
                    wait_cnt_nxt_s  = 4'd0;
                    discard_nxt_s   = 1'b0;
                    mem_req_nxt_s   = 1'b1;
                    mem_we_nxt_s    = 1'b0;
                    mem_addr_nxt_s  = if_addr;
                    mem_size_nxt_s  = FETCH_SIZE;
                end else begin
                    state_nxt_s     = IDLE;
                end
            end

            DATA: begin
                if (mem_ack) begin
                    state_nxt_s   = IDLE;
                    mem_req_nxt_s = 1'b0;
                    dm_done_nxt_s = 1'b1;
                    if (!mem_we_r) begin
                        dm_rdata_nxt_s = mem_rdata;
                    end else begin
                        dm_rdata_nxt_s = dm_rdata_r;
                    end
                end else if (timeout_s) begin
                    state_nxt_s    = IDLE;
                    mem_req_nxt_s  = 1'b0;
                    wait_cnt_nxt_s = WAIT_MAX;
                    mem_err_nxt_s  = 1'b1;
                    dm_done_nxt_s  = 1'b1;
                    dm_rdata_nxt_s = 32'h0000_0000;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r + 4'd1;
                end
            end

            FETCH: begin
                // Sticky: any flush seen after the grant, including at the
                // ack edge itself, makes the returning word stale.
                discard_nxt_s = discard_r | flush;
                if (mem_ack) begin
                    state_nxt_s   = IDLE;
                    mem_req_nxt_s = 1'b0;
                    if (discard_r || flush) begin
                        if_valid_nxt_s = 1'b0;
                    end else begin
                        if_valid_nxt_s = 1'b1;
                        if_rdata_nxt_s = mem_rdata;
                    end
                end else if (timeout_s) begin
                    state_nxt_s    = IDLE;
                    mem_req_nxt_s  = 1'b0;
                    wait_cnt_nxt_s = WAIT_MAX;
                    mem_err_nxt_s  = 1'b1;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r + 4'd1;
                end
            end

            default: begin
                state_nxt_s    = IDLE;
                wait_cnt_nxt_s = 4'd0;
                discard_nxt_s  = 1'b0;
                mem_req_nxt_s  = 1'b0;
            end
        endcase
    end

    // FSM state, wait counter and discard flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            wait_cnt_r <= 4'd0;
            discard_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            discard_r  <= discard_nxt_s;
        end
    end

    // Registered memory-port and pipeline-facing outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_wdata_r <= 32'h0000_0000;
            mem_size_r  <= 3'b000;
            if_rdata_r  <= 32'h0000_0000;
            if_valid_r  <= 1'b0;
            dm_rdata_r  <= 32'h0000_0000;
            dm_done_r   <= 1'b0;
            mem_err_r   <= 1'b0;
        end else begin
            mem_req_r   <= mem_req_nxt_s;
            mem_we_r    <= mem_we_nxt_s;
            mem_addr_r  <= mem_addr_nxt_s;
            mem_wdata_r <= mem_wdata_nxt_s;
            mem_size_r  <= mem_size_nxt_s;
            if_rdata_r  <= if_rdata_nxt_s;
            if_valid_r  <= if_valid_nxt_s;
            dm_rdata_r  <= dm_rdata_nxt_s;
            dm_done_r   <= dm_done_nxt_s;
            mem_err_r   <= mem_err_nxt_s;
        end
    end

endmodule
